// File: rtl/ebus_responder_if.sv
// EBUS controller/device signal bundle for one responder slot.
// The controller side uses the master modport and the device side uses the slave modport.
interface ebus_responder_if;
  logic [0:6]  ebusDS;
  logic [0:2]  ebusFunc;
  logic        ebusDemand;
  logic [0:35] ebusDataIn;
  logic        ebusXfer;
  logic        ebusDriving;
  logic [0:35] ebusDataOut;

  modport master (
    output ebusDS, ebusFunc, ebusDemand, ebusDataIn,
    input  ebusXfer, ebusDriving, ebusDataOut
  );

  modport slave (
    input  ebusDS, ebusFunc, ebusDemand, ebusDataIn,
    output ebusXfer, ebusDriving, ebusDataOut
  );
endinterface

// File: rtl/ebus_responder.sv
// EBUS device responder: decodes the device select, runs the demand/xfer handshake and
// executes CONO/CONI/DATAO/DATAI against a control register and a DATAI holding word.
//
// state   | meaning
// IDLE    | waiting for a demand addressed to DEV_ID with func 0-3
// WAIT    | counting down WAIT_CYC cycles; read data is already driven
// XFER    | xfer asserted; write side effects are applied on entry
// RELEASE | demand has fallen, xfer and drive dropped; back to IDLE next cycle
module ebus_responder #(
  parameter logic [0:6] DEV_ID   = 7'o010,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic            eboxClk,
  input  logic            eboxReset,
  ebus_responder_if.slave ebus,
  input  logic [0:35]     devWord,
  input  logic            devLoad,
  output logic [0:35]     devOut,
  output logic            devStrobe,
  output logic [1:7]      piReq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] F_CONO  = 2'd0;
  localparam logic [1:0] F_DATAO = 2'd2;
  localparam logic [1:0] F_DATAI = 2'd3;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [1:0]  lat_func;
  logic [0:35] lat_data;
  logic [0:35] hold_reg;
  logic        full;
  logic        accept;
  logic        xfer_entry;
  logic        drive;
  logic        full_clr;
  logic [0:35] coni_word;
  logic [0:35] rd_word;

  // conReg bit 32 is never stored: CONI reports the full flag in that position.
  logic [24:31] conReg_hi;
  logic [33:35] pia;

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    xfer_entry = 1'b0;
    case (state)
      IDLE: begin
        if (ebus.ebusDemand && (ebus.ebusDS == DEV_ID) && !ebus.ebusFunc[0]) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!ebus.ebusDemand) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          xfer_entry = 1'b1;
          state_nxt  = XFER;
        end
      end
      XFER: begin
        if (!ebus.ebusDemand) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CONI and DATAI both have the low function bit set.
  always_comb begin
    drive            = ((state == WAIT) || (state == XFER)) && lat_func[0];
    coni_word        = {24'd0, conReg_hi, full, pia};
    rd_word          = (lat_func == F_DATAI) ? hold_reg : coni_word;
    ebus.ebusXfer    = (state == XFER);
    ebus.ebusDriving = drive;
    ebus.ebusDataOut = drive ? rd_word : 36'd0;
  end

  always_comb begin
    full_clr = xfer_entry &&
               ((lat_func == F_DATAI) || ((lat_func == F_CONO) && lat_data[25]));
  end

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      cnt      <= 4'd0;
      lat_func <= 2'd0;
      lat_data <= 36'd0;
    end else if (accept) begin
      cnt      <= 4'(WAIT_CYC);
      lat_func <= ebus.ebusFunc[1:2];
      lat_data <= ebus.ebusDataIn;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      conReg_hi <= 8'd0;
      pia       <= 3'd0;
      devOut    <= 36'd0;
      devStrobe <= 1'b0;
    end else begin
      devStrobe <= 1'b0;
      if (xfer_entry && (lat_func == F_CONO)) begin
        conReg_hi <= lat_data[24:31];
        pia       <= lat_data[33:35];
      end
      if (xfer_entry && (lat_func == F_DATAO)) begin
        devOut    <= lat_data;
        devStrobe <= 1'b1;
      end
    end
  end

  // A device load always wins over a clear arriving on the same cycle.
  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      hold_reg <= 36'd0;
      full     <= 1'b0;
    end else if (devLoad) begin
      hold_reg <= devWord;
      full     <= 1'b1;
    end else if (full_clr) begin
      full <= 1'b0;
    end
  end

  always_comb begin
    piReq = 7'd0;
    for (int n = 1; n <= 7; n++) begin
      piReq[n] = full && (pia == 3'(n));
    end
  end

endmodule

// File: tb/tb_ebus_responder.sv
// Self-checking bench for ebus_responder: directed vector table, corner-case sequences
// and randomized operations checked against a transaction-level model of the device.
module tb_ebus_responder;
  localparam logic [0:6] DEV_ID   = 7'o010;
  localparam int         WAIT_CYC = 2;

  logic        eboxClk = 1'b0;
  logic        eboxReset = 1'b1;
  logic [0:35] devWord;
  logic        devLoad;
  logic [0:35] devOut;
  logic        devStrobe;
  logic [1:7]  piReq;

  ebus_responder_if ebus ();

  ebus_responder #(.DEV_ID(DEV_ID), .WAIT_CYC(WAIT_CYC)) dut (
    .eboxClk  (eboxClk),
    .eboxReset(eboxReset),
    .ebus     (ebus),
    .devWord  (devWord),
    .devLoad  (devLoad),
    .devOut   (devOut),
    .devStrobe(devStrobe),
    .piReq    (piReq)
  );

  always #5 eboxClk = ~eboxClk;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;

  always @(negedge eboxClk) if (devStrobe) strobe_cnt <= strobe_cnt + 1;

  // Device model: control bits 24..35 as a 12-bit number, holding word, full flag, devOut.
  logic [11:0] m_con;
  logic [35:0] m_hold;
  logic [35:0] m_devout;
  logic        m_full;

  function automatic logic [35:0] coni_word();
    return {24'd0, (m_con & ~12'o0010) | (m_full ? 12'o0010 : 12'o0000)};
  endfunction

  function automatic logic [6:0] pi_expect();
    int pia;
    pia = int'(m_con % 12'd8);
    if (!m_full || pia == 0) return 7'd0;
    return 7'(1 << (7 - pia));
  endfunction

  task automatic model_reset();
    m_con = 12'd0; m_hold = 36'd0; m_devout = 36'd0; m_full = 1'b0;
  endtask

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %o want %o", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge eboxClk);
    #1;
  endtask

  task automatic load(input logic [35:0] word);
    devLoad = 1'b1;
    devWord = word;
    tick();
    devLoad = 1'b0;
    m_hold = word;
    m_full = 1'b1;
    check("load piReq", 36'(piReq), 36'(pi_expect()));
  endtask

  task automatic txn(input logic [2:0] func, input logic [35:0] data, input int hold,
                     input logic co_load, input logic [35:0] co_word,
                     output logic [35:0] seen);
    logic        is_rd;
    logic        clr;
    logic [35:0] exp_rd;
    int          n;
    int          s0;
    int          lost;
    is_rd  = (func == 3'd1) || (func == 3'd3);
    s0     = strobe_cnt;
    exp_rd = (func == 3'd3) ? m_hold : coni_word();
    ebus.ebusDS     = DEV_ID;
    ebus.ebusFunc   = func;
    ebus.ebusDataIn = data;
    ebus.ebusDemand = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1 && is_rd) begin
        check("wait driving", 36'(ebus.ebusDriving), 36'd1);
        check("wait data", ebus.ebusDataOut, exp_rd);
      end
      if (co_load && n == WAIT_CYC + 1) begin
        devLoad = 1'b1;
        devWord = co_word;
      end
    end while (!ebus.ebusXfer && n < 40);
    devLoad = 1'b0;
    check("xfer latency", 36'(n - 1), 36'(WAIT_CYC + 1));

    clr = (func == 3'd3) || (func == 3'd0 && data[10]);
    if (func == 3'd0) m_con = data[11:0];
    if (func == 3'd2) m_devout = data;
    if (co_load) begin
      m_hold = co_word;
      m_full = 1'b1;
    end else if (clr) begin
      m_full = 1'b0;
    end
    exp_rd = (func == 3'd3) ? m_hold : coni_word();

    check("xfer high", 36'(ebus.ebusXfer), 36'd1);
    check("xfer driving", 36'(ebus.ebusDriving), 36'(is_rd));
    check("xfer data", ebus.ebusDataOut, is_rd ? exp_rd : 36'd0);
    check("devOut", devOut, m_devout);
    seen = is_rd ? ebus.ebusDataOut : devOut;
    lost = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!ebus.ebusXfer) lost++;
    end
    check("xfer held", 36'(lost), 36'd0);
    ebus.ebusDemand = 1'b0;
    tick();
    check("xfer fall", 36'(ebus.ebusXfer), 36'd0);
    check("release driving", 36'(ebus.ebusDriving), 36'd0);
    tick();
    check("strobe count", 36'(strobe_cnt - s0), (func == 3'd2) ? 36'd1 : 36'd0);
    check("piReq", 36'(piReq), 36'(pi_expect()));
  endtask

  task automatic ignore(input logic [6:0] ds, input logic [2:0] func, input int cycles);
    int act;
    int s0;
    s0  = strobe_cnt;
    act = 0;
    ebus.ebusDS     = ds;
    ebus.ebusFunc   = func;
    ebus.ebusDataIn = 36'o000000002777;
    ebus.ebusDemand = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (ebus.ebusXfer || ebus.ebusDriving) act++;
    end
    ebus.ebusDemand = 1'b0;
    tick();
    check("ignored activity", 36'(act), 36'd0);
    check("ignored strobe", 36'(strobe_cnt - s0), 36'd0);
    check("ignored piReq", 36'(piReq), 36'(pi_expect()));
  endtask

  task automatic abort_txn(input logic [2:0] func, input logic [35:0] data, input int m);
    int act;
    int s0;
    s0  = strobe_cnt;
    act = 0;
    ebus.ebusDS     = DEV_ID;
    ebus.ebusFunc   = func;
    ebus.ebusDataIn = data;
    ebus.ebusDemand = 1'b1;
    for (int i = 0; i < m; i++) begin
      tick();
      if (ebus.ebusXfer) act++;
    end
    ebus.ebusDemand = 1'b0;
    tick();
    if (ebus.ebusXfer) act++;
    tick();
    check("abort xfer", 36'(act), 36'd0);
    check("abort driving", 36'(ebus.ebusDriving), 36'd0);
    check("abort strobe", 36'(strobe_cnt - s0), 36'd0);
    check("abort devOut", devOut, m_devout);
    check("abort piReq", 36'(piReq), 36'(pi_expect()));
  endtask

  typedef struct {
    int          op;       // 0..3 = EBUS function, 4 = device load
    logic [35:0] data;
    logic [35:0] exp_rd;   // read data for CONI/DATAI, devOut for DATAO
    logic [6:0]  exp_pi;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [35:0] seen;
    logic [35:0] d;
    logic [6:0]  ds;
    int          n;

    ebus.ebusDS = 7'd0; ebus.ebusFunc = 3'd0; ebus.ebusDataIn = 36'd0; ebus.ebusDemand = 1'b0;
    devLoad = 1'b0; devWord = 36'd0;
    model_reset();

    tbl[0]  = '{4, 36'o777000000111, 36'd0,                 7'b0000000};
    tbl[1]  = '{3, 36'd0,            36'o777000000111,      7'b0000000};
    tbl[2]  = '{1, 36'd0,            36'd0,                 7'b0000000};
    tbl[3]  = '{0, 36'o000000000005, 36'd0,                 7'b0000000};
    tbl[4]  = '{4, 36'o000000000001, 36'd0,                 7'b0000100};
    tbl[5]  = '{1, 36'd0,            36'o000000000015,      7'b0000100};
    tbl[6]  = '{0, 36'o000000002005, 36'd0,                 7'b0000000};
    tbl[7]  = '{1, 36'd0,            36'o000000002005,      7'b0000000};
    tbl[8]  = '{2, 36'o123456701234, 36'o123456701234,      7'b0000000};
    tbl[9]  = '{0, 36'o000000000777, 36'd0,                 7'b0000000};
    tbl[10] = '{4, 36'o000000000555, 36'd0,                 7'b0000001};
    tbl[11] = '{1, 36'd0,            36'o000000000777,      7'b0000001};
    tbl[12] = '{3, 36'd0,            36'o000000000555,      7'b0000000};
    tbl[13] = '{1, 36'd0,            36'o000000000767,      7'b0000000};

    tick();
    check("reset xfer", 36'(ebus.ebusXfer), 36'd0);
    check("reset driving", 36'(ebus.ebusDriving), 36'd0);
    check("reset dataOut", ebus.ebusDataOut, 36'd0);
    check("reset devOut", devOut, 36'd0);
    check("reset strobe", 36'(devStrobe), 36'd0);
    check("reset piReq", 36'(piReq), 36'd0);
    eboxReset = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].op == 4) begin
        load(tbl[i].data);
      end else begin
        txn(3'(tbl[i].op), tbl[i].data, i % 3, 1'b0, 36'd0, seen);
        if (tbl[i].op != 0) check($sformatf("vec%0d data", i), seen, tbl[i].exp_rd);
      end
      check($sformatf("vec%0d piReq", i), 36'(piReq), 36'(tbl[i].exp_pi));
    end

    // Load coinciding with DATAI entry and with a CONO that clears full.
    txn(3'd0, 36'o000000000003, 0, 1'b0, 36'd0, seen);
    load(36'o111);
    check("lvl3 piReq", 36'(piReq), 36'(7'b0010000));
    txn(3'd3, 36'd0, 1, 1'b1, 36'o222, seen);
    check("datai vs load data", seen, 36'o222);
    check("datai vs load piReq", 36'(piReq), 36'(7'b0010000));
    txn(3'd0, 36'o000000002003, 0, 1'b1, 36'o333, seen);
    check("cono25 vs load piReq", 36'(piReq), 36'(7'b0010000));
    txn(3'd1, 36'd0, 0, 1'b0, 36'd0, seen);
    check("coni full", seen, 36'o000000002013);
    txn(3'd0, 36'o000000002003, 0, 1'b0, 36'd0, seen);
    check("cono25 clear piReq", 36'(piReq), 36'd0);
    load(36'o444);

    ignore(7'(DEV_ID + 7'd1), 3'd0, 20);
    ignore(DEV_ID, 3'd5, 20);

    abort_txn(3'd2, 36'o707070707070, WAIT_CYC + 1);
    abort_txn(3'd0, 36'o000000002777, 1);
    txn(3'd1, 36'd0, 0, 1'b0, 36'd0, seen);
    check("coni after abort", seen, 36'o000000002013);

    // Reset in the middle of a CONI transfer, with demand still high on release.
    ebus.ebusDS = DEV_ID; ebus.ebusFunc = 3'd1; ebus.ebusDataIn = 36'd0; ebus.ebusDemand = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ebus.ebusXfer && n < 40);
    check("pre-reset xfer", 36'(ebus.ebusXfer), 36'd1);
    eboxReset = 1'b1;
    #1;
    check("async rst xfer", 36'(ebus.ebusXfer), 36'd0);
    check("async rst driving", 36'(ebus.ebusDriving), 36'd0);
    check("async rst dataOut", ebus.ebusDataOut, 36'd0);
    check("async rst devOut", devOut, 36'd0);
    check("async rst strobe", 36'(devStrobe), 36'd0);
    check("async rst piReq", 36'(piReq), 36'd0);
    tick();
    eboxReset = 1'b0;
    model_reset();
    n = 0;
    do begin
      tick();
      n++;
    end while (!ebus.ebusXfer && n < 40);
    check("post-reset latency", 36'(n - 1), 36'(WAIT_CYC + 1));
    check("post-reset coni", ebus.ebusDataOut, coni_word());
    ebus.ebusDemand = 1'b0;
    tick();
    tick();

    for (int k = 0; k < 150; k++) begin
      d = {4'($urandom), 32'($urandom)};
      case ($urandom_range(0, 9))
        0, 1, 2, 3: txn(3'($urandom_range(0, 3)), d, $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0), {4'($urandom), 32'($urandom)}, seen);
        4, 5:       load(d);
        6: begin
          ds = 7'($urandom_range(0, 127));
          if (ds == DEV_ID) ds = ds + 7'd1;
          ignore(ds, 3'($urandom_range(0, 3)), 5);
        end
        7:          ignore(DEV_ID, 3'($urandom_range(4, 7)), 5);
        8:          abort_txn(3'($urandom_range(0, 3)), d, $urandom_range(1, WAIT_CYC + 1));
        default:    txn(3'd1, d, 0, 1'b0, 36'd0, seen);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
